// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace transmitter: frame layout, FSM states, FIFO entry.
// No logic of its own; frame_byte() is a pure mux used by the serialiser.
// Frames are 6 bytes: sync, destination register, then write data MSB first.
package trace_pkg;

    localparam logic [7:0] FRAME_SYNC  = 8'hA5;
    localparam int         FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } entry_t;

    function automatic logic [7:0] frame_byte(input entry_t e, input logic [2:0] idx);
        case (idx)
            3'd0:    frame_byte = FRAME_SYNC;
            3'd1:    frame_byte = {3'b000, e.rd};
            3'd2:    frame_byte = e.wdata[31:24];
            3'd3:    frame_byte = e.wdata[23:16];
            3'd4:    frame_byte = e.wdata[15:8];
            default: frame_byte = e.wdata[7:0];
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with registered read data (rdata updates on the pop edge).
// Latency: push visible as non-empty one cycle later; popped word valid the cycle after pop.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_tx.sv
// Streams register write-back commits out of a UART as 6-byte frames; TRACE_PARITY_EN adds even parity.
// Latency: start bit begins 2 cycles after a commit into an idle, empty transmitter.
// Backpressure: none upstream; commits arriving to a full FIFO are dropped and flag overflow.
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wdata,
    output logic        uart_tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam logic [15:0] TICK_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_t   state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic        tx_active;
    logic        tick;
    logic        capture;
    logic        pop;
    logic        fifo_empty;
    logic        line_bit;
    logic [7:0]  cur_byte;
    entry_t      wr_entry;
    entry_t      rd_entry;

    assign capture  = wb_reg_write && (wb_rd != 5'd0);
    assign wr_entry = '{rd: wb_rd, wdata: wb_wdata};
    assign tick     = (clk_cnt == TICK_MAX);
    assign pop      = !fifo_empty &&
                      ((state == IDLE) || (state == STOP && tick && byte_idx == LAST_BYTE));
    assign cur_byte = frame_byte(rd_entry, byte_idx);
    assign busy     = tx_active || (state != IDLE) || !fifo_empty;

    trace_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (capture && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = cur_byte[bit_idx];
            PARITY:  line_bit = ^cur_byte;
            default: line_bit = 1'b1;
        endcase
    end

    // The line register trails the state by one cycle, so every bit keeps its full width
    // and the pop edge doubles as the setup cycle for the popped entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            uart_tx   <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            uart_tx   <= line_bit;
            tx_active <= (state != IDLE);
            if (state == IDLE || tick) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= START;
                        byte_idx <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef TRACE_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end else if (!fifo_empty) begin
                            byte_idx <= '0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
